adc_scan_sched: RTL

- Autonomous channel-scan sequencer for the AD7938 ADC front end.
- Sits between the host register port and the ADC control/readback registers of the data-in block.
- Walks an 8-bit channel mask and programs channel, averaging depth and enable into the ADC control word. It then polls the ready flag and stores each 12-bit averaged result in a per-channel result bank the host reads back.
- Frees the host from per-channel handshaking; supports single-pass and continuous scanning.

---
 rtl/adc_scan_sched.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/adc_scan_sched.sv
// Autonomous AD7938 channel-scan sequencer: walks a channel mask, programs the
// ADC control word, polls ready and banks each 12-bit result per channel.
module adc_scan_sched #(
  parameter int unsigned EN_BIT  = 0,
  parameter int unsigned CH_LSB  = 4,
  parameter int unsigned DEV_LSB = 8,
  parameter int unsigned SETTLE  = 4,
  parameter logic [15:0] TIMEOUT = 16'd40000
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        adc_sel,
  output logic        out_sel,
  output logic        adc_valid,
  output logic        adc_rd_wr,
  output logic [31:0] adc_wdata,
  input  logic [31:0] adc_rdata,
  output logic        scan_done,
  output logic        scan_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_SETTLE, S_WAIT_BUSY, S_WAIT_DONE, S_CAPTURE, S_NEXT
  } state_t;

  state_t      r_state;
  logic        r_run, r_cont, r_err, r_done;
  logic [7:0]  r_mask;
  logic [8:0]  r_avg;
  logic [2:0]  r_ch;
  logic [7:0]  r_settle_cnt;
  logic [2:0]  r_busy_cnt;
  logic [15:0] r_to_cnt;
  logic [15:0] r_pass;
  logic [7:0]  r_res_valid;
  logic [11:0] r_res_data [8];
  logic        r_adc_sel, r_out_sel, r_adc_valid, r_adc_rd_wr;
  logic [31:0] r_adc_wdata;

  state_t      w_nxt;
  logic [2:0]  w_nch, w_lo, w_hi;
  logic        w_lo_found, w_hi_found;
  logic        w_timeout, w_pass_end, w_nxt_rd, w_active;
  logic [8:0]  w_avg_in;
  logic        w_avg_ok;
  logic        w_unused;

  function automatic logic [31:0] ctrl_word(input logic [2:0] ch, input logic [8:0] avg);
    logic [31:0] w;
    w = '0;
    w[EN_BIT]        = 1'b1;
    w[CH_LSB +: 3]   = ch;
    w[DEV_LSB +: 9]  = avg;
    return w;
  endfunction

  assign w_unused = ^{adc_rdata[31:13], cfg_wdata[31:25], cfg_wdata[7:2]};

  assign w_avg_in  = cfg_wdata[24:16];
  assign w_avg_ok  = (w_avg_in != '0) && ((w_avg_in & (w_avg_in - 9'd1)) == '0);
  assign w_active  = (r_state != S_IDLE);
  assign w_timeout = ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE)) &&
                     (r_to_cnt == TIMEOUT - 16'd1);
  assign w_nxt_rd  = (w_nxt == S_SETTLE) || (w_nxt == S_WAIT_BUSY) ||
                     (w_nxt == S_WAIT_DONE) || (w_nxt == S_CAPTURE);

  // Lowest set mask bit, and lowest set bit strictly above the current channel.
  always_comb begin
    w_lo = '0;
    w_hi = '0;
    w_lo_found = 1'b0;
    w_hi_found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r_mask[i] && !w_lo_found) begin
        w_lo = 3'(i);
        w_lo_found = 1'b1;
      end
      if (r_mask[i] && !w_hi_found && (i > 32'(r_ch))) begin
        w_hi = 3'(i);
        w_hi_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_nch      = r_ch;
    w_pass_end = 1'b0;
    case (r_state)
      S_IDLE:
        if (r_run && (r_mask != '0)) begin
          w_nxt = S_WRITE;
          w_nch = w_lo;
        end
      S_WRITE:  w_nxt = S_SETTLE;
      S_SETTLE: if (r_settle_cnt == 8'(SETTLE - 1)) w_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY:
        if (w_timeout)              w_nxt = S_NEXT;
        else if (!adc_rdata[12])    w_nxt = S_WAIT_DONE;
        else if (r_busy_cnt == 3'd7) w_nxt = S_CAPTURE;
      S_WAIT_DONE:
        if (w_timeout)              w_nxt = S_NEXT;
        else if (adc_rdata[12])     w_nxt = S_CAPTURE;
      S_CAPTURE: w_nxt = S_NEXT;
      S_NEXT:
        if (!r_run) begin
          w_nxt = S_IDLE;
        end else if (w_hi_found) begin
          w_nxt = S_WRITE;
          w_nch = w_hi;
        end else begin
          w_pass_end = 1'b1;
          if (r_cont) begin
            w_nxt = S_WRITE;
            w_nch = w_lo;
          end else begin
            w_nxt = S_IDLE;
          end
        end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state      <= S_IDLE;
      r_run        <= 1'b0;
      r_cont       <= 1'b0;
      r_mask       <= '0;
      r_avg        <= '0;
      r_ch         <= '0;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
      r_settle_cnt <= '0;
      r_busy_cnt   <= '0;
      r_to_cnt     <= '0;
      r_pass       <= '0;
      r_res_valid  <= '0;
      for (int unsigned i = 0; i < 8; i++) r_res_data[i] <= '0;
      r_adc_sel    <= 1'b0;
      r_out_sel    <= 1'b0;
      r_adc_valid  <= 1'b0;
      r_adc_rd_wr  <= 1'b1;
      r_adc_wdata  <= '0;
    end else begin
      r_state     <= w_nxt;
      r_ch        <= w_nch;
      // Strobes are decoded from the upcoming state so they align with it.
      r_adc_sel   <= (w_nxt == S_WRITE);
      r_adc_valid <= (w_nxt == S_WRITE);
      r_out_sel   <= w_nxt_rd;
      r_adc_rd_wr <= !w_nxt_rd;
      if (w_nxt == S_WRITE) r_adc_wdata <= ctrl_word(w_nch, r_avg);

      r_settle_cnt <= (r_state == S_SETTLE)    ? r_settle_cnt + 8'd1 : '0;
      r_busy_cnt   <= (r_state == S_WAIT_BUSY) ? r_busy_cnt + 3'd1   : '0;
      r_to_cnt     <= ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE)) ?
                      r_to_cnt + 16'd1 : '0;

      r_done <= w_pass_end;
      if (w_pass_end) begin
        r_pass <= r_pass + 16'd1;
        if (!r_cont) r_run <= 1'b0;
      end

      if (w_timeout) begin
        r_err <= 1'b1;
        r_res_valid[r_ch] <= 1'b0;
      end
      if (r_state == S_CAPTURE) begin
        r_res_valid[r_ch] <= 1'b1;
        r_res_data[r_ch]  <= adc_rdata[11:0];
      end

      // Placed last so a host write overrides the end-of-pass run clear.
      if (cfg_we && (cfg_addr == 4'h0)) begin
        r_run <= cfg_wdata[0];
        r_err <= 1'b0;
        if (!w_active) begin
          r_cont <= cfg_wdata[1];
          r_mask <= cfg_wdata[15:8];
          r_avg  <= w_avg_ok ? w_avg_in : 9'd1;
        end
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    if (cfg_addr[3])
      cfg_rdata = {r_res_valid[cfg_addr[2:0]], 19'b0, r_res_data[cfg_addr[2:0]]};
    else if (cfg_addr == 4'h0)
      cfg_rdata = {7'b0, r_avg, r_mask, 6'b0, r_cont, r_run};
    else if (cfg_addr == 4'h1)
      cfg_rdata = {r_pass, 11'b0, r_err, r_ch, w_active};
  end

  assign adc_sel   = r_adc_sel;
  assign out_sel   = r_out_sel;
  assign adc_valid = r_adc_valid;
  assign adc_rd_wr = r_adc_rd_wr;
  assign adc_wdata = r_adc_wdata;
  assign scan_done = r_done;
  assign scan_err  = r_err;

endmodule
